// File: rtl/isp_pkg.sv
// Shared widths and constants for the pixel-processing pipeline stages.
package isp_pkg;
  localparam int PIX_W = 8;
  localparam int SUM_W = 10;
  localparam int MAG_W = 11;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  // Unsigned |a - b| without signed arithmetic: always larger minus smaller.
  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sobel_kernel_3x3.sv
// Sobel datapath: weighted partial sums, then |Gx| and |Gy|. Two registered stages.
// No backpressure: each stage loads on its enable and holds otherwise.
import isp_pkg::*;

module sobel_kernel_3x3 (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             s1_en_i,
  input  logic             s2_en_i,
  input  logic [PIX_W-1:0] p11_i,
  input  logic [PIX_W-1:0] p12_i,
  input  logic [PIX_W-1:0] p13_i,
  input  logic [PIX_W-1:0] p21_i,
  input  logic [PIX_W-1:0] p23_i,
  input  logic [PIX_W-1:0] p31_i,
  input  logic [PIX_W-1:0] p32_i,
  input  logic [PIX_W-1:0] p33_i,
  output logic [SUM_W-1:0] gx_abs_o,
  output logic [SUM_W-1:0] gy_abs_o
);
  logic [SUM_W-1:0] gx_p_d, gx_n_d, gy_p_d, gy_n_d;
  logic [SUM_W-1:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [SUM_W-1:0] gx_abs_q, gy_abs_q;

  // Column 3 / row 3 are the positive sides of Gx / Gy.
  always_comb begin
    gx_p_d = SUM_W'(p13_i) + (SUM_W'(p23_i) << 1) + SUM_W'(p33_i);
    gx_n_d = SUM_W'(p11_i) + (SUM_W'(p21_i) << 1) + SUM_W'(p31_i);
    gy_p_d = SUM_W'(p31_i) + (SUM_W'(p32_i) << 1) + SUM_W'(p33_i);
    gy_n_d = SUM_W'(p11_i) + (SUM_W'(p12_i) << 1) + SUM_W'(p13_i);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gx_p_q   <= '0;
      gx_n_q   <= '0;
      gy_p_q   <= '0;
      gy_n_q   <= '0;
      gx_abs_q <= '0;
      gy_abs_q <= '0;
    end else begin
      if (s1_en_i) begin
        gx_p_q <= gx_p_d;
        gx_n_q <= gx_n_d;
        gy_p_q <= gy_p_d;
        gy_n_q <= gy_n_d;
      end
      if (s2_en_i) begin
        gx_abs_q <= abs_diff(gx_p_q, gx_n_q);
        gy_abs_q <= abs_diff(gy_p_q, gy_n_q);
      end
    end
  end

  assign gx_abs_o = gx_abs_q;
  assign gy_abs_o = gy_abs_q;
endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel edge/magnitude stage, 3-cycle latency from matrix_wr_en to edge_wr_en.
// No backpressure: one pixel per cycle in, leading MASK_COLS columns of each line forced to 0x00.
import isp_pkg::*;

module sobel_edge_detect #(
  parameter int OUT_MODE  = 0,
  parameter int MASK_COLS = 2,
  parameter int COL_W     = 11
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             matrix_wr_en,
  input  logic             matrix_href,
  input  logic             sobel_en,
  input  logic [PIX_W-1:0] matrix_p11,
  input  logic [PIX_W-1:0] matrix_p12,
  input  logic [PIX_W-1:0] matrix_p13,
  input  logic [PIX_W-1:0] matrix_p21,
  input  logic [PIX_W-1:0] matrix_p22,
  input  logic [PIX_W-1:0] matrix_p23,
  input  logic [PIX_W-1:0] matrix_p31,
  input  logic [PIX_W-1:0] matrix_p32,
  input  logic [PIX_W-1:0] matrix_p33,
  input  logic [PIX_W-1:0] threshold,
  output logic             edge_wr_en,
  output logic             edge_href,
  output logic [PIX_W-1:0] edge_data
);
  logic [2:0]       vld_q, href_q;
  logic [1:0]       mask_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [PIX_W-1:0] edge_q, edge_d;
  logic [SUM_W-1:0] gx_abs, gy_abs;
  logic [MAG_W-1:0] mag;
  logic             center_unused;

  // The Sobel kernels have zero weight on the centre pixel.
  assign center_unused = ^matrix_p22;

  sobel_kernel_3x3 u_kernel (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .s1_en_i   (matrix_wr_en),
    .s2_en_i   (vld_q[0]),
    .p11_i     (matrix_p11),
    .p12_i     (matrix_p12),
    .p13_i     (matrix_p13),
    .p21_i     (matrix_p21),
    .p23_i     (matrix_p23),
    .p31_i     (matrix_p31),
    .p32_i     (matrix_p32),
    .p33_i     (matrix_p33),
    .gx_abs_o  (gx_abs),
    .gy_abs_o  (gy_abs)
  );

  always_comb begin
    col_d = col_q;
    if (!matrix_href)
      col_d = '0;
    else if (matrix_wr_en && (col_q != '1))
      col_d = col_q + 1'b1;
  end

  assign mag = MAG_W'(gx_abs) + MAG_W'(gy_abs);

  always_comb begin
    edge_d = EDGE_OFF;
    if (mask_q[1])
      edge_d = EDGE_OFF;
    else if (OUT_MODE == 0)
      edge_d = (mag > MAG_W'(threshold)) ? EDGE_ON : EDGE_OFF;
    else
      edge_d = (mag > MAG_W'(255)) ? EDGE_ON : mag[PIX_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q  <= '0;
      href_q <= '0;
      mask_q <= '0;
      col_q  <= '0;
      edge_q <= '0;
    end else begin
      vld_q  <= {vld_q[1:0], matrix_wr_en & sobel_en};
      href_q <= {href_q[1:0], matrix_href};
      col_q  <= col_d;
      if (matrix_wr_en) mask_q[0] <= (col_q < COL_W'(MASK_COLS));
      if (vld_q[0])     mask_q[1] <= mask_q[0];
      if (vld_q[1])     edge_q    <= edge_d;
    end
  end

  assign edge_wr_en = vld_q[2] | (center_unused & 1'b0);
  assign edge_href  = href_q[2];
  assign edge_data  = edge_q;
endmodule

// File: tb/tb_sobel_edge_detect.sv
// Bench: binary and magnitude instances share stimulus; a convolution-based model predicts each output.
module tb_sobel_edge_detect;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       matrix_wr_en = 1'b0, matrix_href = 1'b0, sobel_en = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic [7:0] pw [0:2][0:2];
  logic       bin_wr, bin_href, mag_wr, mag_href;
  logic [7:0] bin_data, mag_data;

  int total = 0, bad = 0;
  int cyc = 0, thr_s = 0, col_m = 0, pulses = 0;
  int last_bin = 0, last_mag = 0;
  bit chk_en = 0;

  typedef struct { int due; int mag; bit mask; } exp_t;
  exp_t q[$];
  bit href_at[int];

  always #5 sys_clk = ~sys_clk;

  sobel_edge_detect #(.OUT_MODE(0)) u_bin (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .matrix_wr_en(matrix_wr_en),
    .matrix_href(matrix_href), .sobel_en(sobel_en),
    .matrix_p11(pw[0][0]), .matrix_p12(pw[0][1]), .matrix_p13(pw[0][2]),
    .matrix_p21(pw[1][0]), .matrix_p22(pw[1][1]), .matrix_p23(pw[1][2]),
    .matrix_p31(pw[2][0]), .matrix_p32(pw[2][1]), .matrix_p33(pw[2][2]),
    .threshold(threshold), .edge_wr_en(bin_wr), .edge_href(bin_href), .edge_data(bin_data));

  sobel_edge_detect #(.OUT_MODE(1)) u_mag (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .matrix_wr_en(matrix_wr_en),
    .matrix_href(matrix_href), .sobel_en(sobel_en),
    .matrix_p11(pw[0][0]), .matrix_p12(pw[0][1]), .matrix_p13(pw[0][2]),
    .matrix_p21(pw[1][0]), .matrix_p22(pw[1][1]), .matrix_p23(pw[1][2]),
    .matrix_p31(pw[2][0]), .matrix_p32(pw[2][1]), .matrix_p33(pw[2][2]),
    .threshold(threshold), .edge_wr_en(mag_wr), .edge_href(mag_href), .edge_data(mag_data));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sobel by definition: convolve with the Gx/Gy kernels, sum absolute values.
  function automatic int ref_mag();
    int gx = 0, gy = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gx += (c - 1) * ((r == 1) ? 2 : 1) * int'(pw[r][c]);
        gy += (r - 1) * ((c == 1) ? 2 : 1) * int'(pw[r][c]);
      end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  task automatic set_win(input int kind);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        case (kind)
          0:       pw[r][c] = 8'd100;
          1:       pw[r][c] = (c == 2) ? 8'd255 : 8'd0;
          2:       pw[r][c] = (c == 2) ? 8'd10 : 8'd0;
          default: pw[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // One input cycle; kind < 0 leaves the window unchanged.
  task automatic step(input bit we, input bit hr, input int kind);
    bit m;
    @(posedge sys_clk); #1;
    if (kind >= 0) set_win(kind);
    matrix_wr_en = we;
    matrix_href  = hr;
    if (sys_rst_n) begin
      href_at[cyc] = hr;
      if (!hr) col_m = 0;
      else begin
        m = (col_m < 2);
        if (we) col_m++;
        if (we && sobel_en) q.push_back('{cyc + 3, ref_mag(), m});
      end
    end
  endtask

  task automatic run_line(input int kind, input int n, input int gap_pct, input bit chg);
    int sent = 0;
    bit we;
    while (sent < n) begin
      we = ($urandom_range(0, 99) >= gap_pct);
      if (we) sent++;
      step(we, 1'b1, we ? kind : -1);
      if (chg && we && sent == n / 2) threshold = 8'($urandom_range(0, 255));
    end
    step(1'b0, 1'b0, -1);
    step(1'b0, 1'b0, -1);
  endtask

  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    thr_s <= int'(threshold);
  end

  always @(negedge sys_clk) if (bin_wr) pulses++;

  always @(negedge sys_clk) begin
    bit exp_vld;
    int exp_h;
    exp_t e;
    if (chk_en) begin
      exp_vld = (q.size() > 0) && (q[0].due == cyc);
      chk("wr_en_bin", int'(bin_wr), int'(exp_vld));
      chk("wr_en_mag", int'(mag_wr), int'(exp_vld));
      if (exp_vld) begin
        e = q.pop_front();
        last_bin = e.mask ? 0 : ((e.mag > thr_s) ? 255 : 0);
        last_mag = e.mask ? 0 : ((e.mag > 255) ? 255 : e.mag);
      end
      chk("data_bin", int'(bin_data), last_bin);
      chk("data_mag", int'(mag_data), last_mag);
      exp_h = href_at.exists(cyc - 3) ? int'(href_at[cyc - 3]) : 0;
      chk("href_bin", int'(bin_href), exp_h);
      chk("href_mag", int'(mag_href), exp_h);
    end
  end

  initial begin
    int p0;
    set_win(0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_wr_en", int'(bin_wr), 0);
    chk("rst_data", int'(bin_data), 0);
    step(1'b0, 1'b0, -1);

    // Gated: no output while sobel_en is low.
    p0 = pulses;
    run_line(1, 10, 0, 1'b0);
    repeat (4) step(1'b0, 1'b0, -1);
    chk("gated_pulses", pulses - p0, 0);

    sobel_en = 1'b1;
    threshold = 8'd0;
    run_line(0, 8, 0, 1'b0);
    run_line(1, 8, 20, 1'b0);
    threshold = 8'd39;
    run_line(2, 6, 0, 1'b0);
    threshold = 8'd40;
    run_line(2, 6, 0, 1'b0);

    // Ten back-to-back pixels mid-line.
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    repeat (4) step(1'b0, 1'b1, -1);
    p0 = pulses;
    repeat (10) step(1'b1, 1'b1, 3);
    repeat (4) step(1'b0, 1'b1, -1);
    chk("burst_pulses", pulses - p0, 10);
    step(1'b0, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      threshold = 8'($urandom_range(0, 255));
      run_line(3, 20, 30, 1'b1);
    end

    // Reset during the 5th pixel of a line.
    step(1'b0, 1'b1, -1);
    repeat (5) step(1'b1, 1'b1, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_wr_bin", int'(bin_wr), 0);
    chk("arst_wr_mag", int'(mag_wr), 0);
    chk("arst_href", int'(bin_href), 0);
    chk("arst_data_bin", int'(bin_data), 0);
    chk("arst_data_mag", int'(mag_data), 0);
    q.delete();
    href_at.delete();
    col_m = 0;
    last_bin = 0;
    last_mag = 0;
    step(1'b0, 1'b0, -1);
    step(1'b0, 1'b0, -1);
    sys_rst_n = 1'b1;
    run_line(1, 8, 0, 1'b0);

    repeat (6) step(1'b0, 1'b0, -1);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_edge_detect.md
Name: sobel_edge_detect

Overview:
- Consumes the 3x3 8-bit grayscale window from the matrix-generation stage and computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline.
- Outputs either a binary edge map (0x00/0xFF against a runtime threshold) or the saturated 8-bit magnitude.
- Delays wr_en/href alongside the data and blanks the first two columns of each line, where the window still holds stale data.
- Sits between the 3x3 matrix generator and the display/SDRAM write path.

Parameters:
- OUT_MODE, 0: 0 = binary edge (0x00/0xFF); 1 = magnitude saturated to 255.
- MASK_COLS, 2: number of leading columns per line forced to 0x00.
- COL_W, 11: width of the column counter. It must cover the line width (1600 at 11 bits).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- matrix_wr_en  in  1  window valid strobe, one pixel per cycle when high
- matrix_href  in  1  line-active, aligned with matrix_wr_en
- sobel_en  in  1  upstream window primed; level, stays high once set
- matrix_p11..matrix_p33  in  8 each  window pixels; row 1 = oldest line, column 3 = newest pixel
- threshold  in  8  binary-mode threshold, sampled in stage 3
- edge_wr_en  out  1  output pixel valid
- edge_href  out  1  matrix_href delayed 3 cycles
- edge_data  out  8  edge/magnitude pixel

Behaviour:
- Reset: all pipeline registers, counters, edge_wr_en, edge_href and edge_data are 0.
- Stage 1 (registered when matrix_wr_en = 1, otherwise hold). Four 10-bit partial sums:
  - gx_p = p13 + 2·p23 + p33
  - gx_n = p11 + 2·p21 + p31
  - gy_p = p31 + 2·p32 + p33
  - gy_n = p11 + 2·p12 + p13
- Stage 2: gx_abs = |gx_p - gx_n| and gy_abs = |gy_p - gy_n|, each 10 bits, max 1020. Larger-minus-smaller is used, so there is no signed arithmetic.
- Stage 3:
  - mag = gx_abs + gy_abs, 11 bits, max 2040.
  - OUT_MODE = 0: edge_data = 0xFF if mag > {3'b0, threshold} (strict), else 0x00.
  - OUT_MODE = 1: edge_data = 0xFF if mag > 255, else mag[7:0].
- Valid pipeline: v[0..2] shift register fed by (matrix_wr_en & sobel_en).
  - edge_wr_en = v[2]. Latency is exactly 3 cycles from matrix_wr_en to edge_wr_en.
  - Stages advance every cycle. Data registers load only when their stage-input valid is 1, otherwise they hold.
  - edge_data holds its last value while edge_wr_en = 0.
- edge_href: 3-stage shift of matrix_href. It is not gated by sobel_en.
- Column counter:
  - Increments on each matrix_wr_en while matrix_href = 1.
  - Cleared while matrix_href = 0.
  - Saturates at all-ones and never wraps.
- Column mask:
  - A column index < MASK_COLS is carried through the pipeline as a mask bit.
  - A masked pixel produces edge_data = 0x00 with edge_wr_en still asserted, so pixel count is preserved.
- While sobel_en = 0, edge_wr_en stays 0. Column counting continues regardless.
- A matrix_href falling edge while the pipeline is non-empty lets in-flight pixels drain normally. The counter clears the next cycle.
- A threshold change mid-line takes effect on the first pixel reaching stage 3 after the change.
- Reset asserted mid-line clears everything immediately. No partial output appears after release.

Decomposition:
- Shared package isp_pkg holds:
  - PIX_W = 8, SUM_W = 10, MAG_W = 11
  - localparams EDGE_ON = 8'hFF, EDGE_OFF = 8'h00
- One natural sub-module: sobel_kernel_3x3, the pure 2-stage datapath (partial sums, absolute differences) with an enable input.
- The top level adds stage 3, the valid/href/mask delay lines and the column counter.

Test Plan:
- Uniform window, all pixels 100, threshold 0, OUT_MODE 0 → mag 0; edge_data 0x00 on every valid.
- Vertical edge: p13 = p23 = p33 = 255, others 0 → gx_abs 1020, gy_abs 0; edge_data 0xFF (mode 0) and 0xFF saturated (mode 1).
- Threshold boundary: p13 = p23 = p33 = 10, others 0 → mag 40. Expected edge_data:
  - threshold 39 → 0xFF
  - threshold 40 → 0x00
  - OUT_MODE 1 → 0x28
- Latency and gating, 10 consecutive valids mid-line with sobel_en = 1:
  - matrix_wr_en first high at cycle N → edge_wr_en first high at N+3, exactly 10 pulses.
  - With sobel_en = 0 → no edge_wr_en pulses.
- Column mask: new line (href rises) with vertical-edge data on every pixel → first 2 outputs are 0x00, the 3rd onward are 0xFF. Repeat on the next line to confirm the counter clears when href is low.
- Reset mid-line: assert sys_rst_n = 0 during the 5th pixel → all outputs 0 asynchronously. After release, the next line behaves as a fresh line, with the first 2 columns masked.
